// File: rtl/fast_command_decoder.sv
// -----------------------------------------------------------------------------
// fast_command_decoder
//
// Serial-to-parallel decoder for the ETROC2 fast-command stream. Takes the
// retimed 320 Mb/s bit stream from the phase adjuster, finds the 8-bit frame
// boundary using the IDLE symbol (0xF0), locks onto it with hysteresis, and,
// while locked, emits one-cycle command pulses aligned to the 40 MHz frame.
//
// Ports:
//   clk320      in   320 MHz bit clock (single clock domain)
//   rstn        in   asynchronous active-low reset
//   fcIn        in   serial fast-command bit, MSB of each frame first
//   aligned     out  high while the decoder is locked
//   frameStrobe out  one-cycle pulse per decoded frame while locked
//   cmdCode     out  [7:0] last frame captured while locked, held between strobes
//   errCount    out  [7:0] saturating invalid-frame counter (FC_ERRCNT_EN only)
//   l1a, bcr, linkReset, chargeInj, wsStart, wsStop
//               out  one-cycle command pulses, coincident with frameStrobe
//
// Parameters:
//   LOCK_COUNT   consecutive IDLE frames at one phase needed to lock (2..15)
//   UNLOCK_COUNT consecutive invalid frames needed to drop lock (1..15)
//
// Build option:
//   FC_ERRCNT_EN  when defined, adds the errCount port and its counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fast_command_decoder #(
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic       clk320,
    input  logic       rstn,
    input  logic       fcIn,
    output logic       aligned,
    output logic       frameStrobe,
    output logic [7:0] cmdCode,
`ifdef FC_ERRCNT_EN
    output logic [7:0] errCount,
`endif
    output logic       l1a,
    output logic       bcr,
    output logic       linkReset,
    output logic       chargeInj,
    output logic       wsStart,
    output logic       wsStop
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [7:0] CODE_IDLE      = 8'hF0;
    localparam logic [7:0] CODE_LINKRESET = 8'h33;
    localparam logic [7:0] CODE_BCR       = 8'h5A;
    localparam logic [7:0] CODE_L1A       = 8'h96;
    localparam logic [7:0] CODE_CHARGEINJ = 8'h69;
    localparam logic [7:0] CODE_WSSTART   = 8'h3C;
    localparam logic [7:0] CODE_WSSTOP    = 8'hA5;

    localparam logic [3:0] LOCK_TH   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_COUNT);

    logic [7:0] sr;
    logic [2:0] ph,      phNxt;
    logic [1:0] state,   stateNxt;
    logic [3:0] idleCnt, idleCntNxt;
    logic [3:0] badCnt,  badCntNxt;
    logic [3:0] badInc;
    logic       boundary;
    logic       isIdle;
    logic       codeValid;
    logic       emit;
    // Pulse vector order: {wsStop, wsStart, chargeInj, linkReset, bcr, l1a}
    logic [5:0] cmdHit;
    logic [5:0] pulses;

    assign boundary = (ph == 3'd7);
    assign isIdle   = (sr == CODE_IDLE);
    assign badInc   = (badCnt == 4'hF) ? badCnt : badCnt + 4'd1;

    assign {wsStop, wsStart, chargeInj, linkReset, bcr, l1a} = pulses;

    // Frame decode. IDLE is valid but drives no command pulse, so at most
    // one bit of cmdHit can ever be set.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        codeValid = 1'b1;
        cmdHit    = 6'b000000;
        case (sr)
            CODE_IDLE:      cmdHit = 6'b000000;
            CODE_L1A:       cmdHit = 6'b000001;
            CODE_BCR:       cmdHit = 6'b000010;
            CODE_LINKRESET: cmdHit = 6'b000100;
            CODE_CHARGEINJ: cmdHit = 6'b001000;
            CODE_WSSTART:   cmdHit = 6'b010000;
            CODE_WSSTOP:    cmdHit = 6'b100000;
            default:        codeValid = 1'b0;
        endcase
    end

    // Alignment FSM. emit marks a boundary whose frame is presented on the
    // outputs. The IDLE that completes the lock is presented too, so aligned
    // and the first frameStrobe rise on the same edge.
    always_comb begin
        stateNxt   = state;
        idleCntNxt = idleCnt;
        badCntNxt  = badCnt;
        phNxt      = ph + 3'd1;
        emit       = 1'b0;
        case (state)
            SEARCH: begin
                if (isIdle) begin
                    // This cycle acts as a boundary; the next one is 8 later.
                    phNxt      = 3'd0;
                    idleCntNxt = 4'd1;
                    stateNxt   = CHECK;
                end
            end
            CHECK: begin
                if (boundary) begin
                    if (!isIdle) begin
                        stateNxt = SEARCH;
                    end else if (idleCnt + 4'd1 >= LOCK_TH) begin
                        stateNxt  = LOCKED;
                        badCntNxt = 4'd0;
                        emit      = 1'b1;
                    end else begin
                        idleCntNxt = idleCnt + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (codeValid) begin
                        badCntNxt = 4'd0;
                    end else begin
                        badCntNxt = badInc;
                        if (badInc >= UNLOCK_TH) begin
                            stateNxt = SEARCH;
                        end
                    end
                end
            end
            default: stateNxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk320 or negedge rstn) begin
        if (!rstn) begin
            sr          <= 8'h00;
            ph          <= 3'd0;
            state       <= SEARCH;
            idleCnt     <= 4'd0;
            badCnt      <= 4'd0;
            aligned     <= 1'b0;
            frameStrobe <= 1'b0;
            cmdCode     <= CODE_IDLE;
            pulses      <= 6'b000000;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            sr          <= {sr[6:0], fcIn};
            ph          <= phNxt;
            state       <= stateNxt;
            idleCnt     <= idleCntNxt;
            badCnt      <= badCntNxt;
            aligned     <= (stateNxt == LOCKED);
            frameStrobe <= emit;
            pulses      <= emit ? cmdHit : 6'b000000;
            if (emit) begin
                cmdCode <= sr;
            end
        end
    end

`ifdef FC_ERRCNT_EN
    always_ff @(posedge clk320 or negedge rstn) begin
        if (!rstn) begin
            errCount <= 8'h00;
        end else if (state == LOCKED && boundary && !codeValid && errCount != 8'hFF) begin
            errCount <= errCount + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fast_command_decoder.sv
`timescale 1ns/1ps

module tb_fast_command_decoder;

    logic       clk320 = 1'b0;
    logic       rstn   = 1'b0;
    logic       fcIn   = 1'b0;
    logic       aligned, frameStrobe;
    logic [7:0] cmdCode;
    logic       l1a, bcr, linkReset, chargeInj, wsStart, wsStop;
`ifdef FC_ERRCNT_EN
    logic [7:0] errCount;
`endif
    logic [5:0] pulses;

    int compared   = 0;
    int mismatched = 0;
    int strobeCnt  = 0;
    int alignedCnt = 0;
    int multiCnt   = 0;
    int pulseCnt [6] = '{default: 0};

    // {wsStop, wsStart, chargeInj, linkReset, bcr, l1a}
    assign pulses = {wsStop, wsStart, chargeInj, linkReset, bcr, l1a};

    typedef struct packed {
        logic       strobe1;
        logic       aligned1;
        logic [7:0] code1;
        logic [5:0] pulses1;
        logic       strobe5;
        logic [7:0] code5;
    } snap_t;

    fast_command_decoder dut (
        .clk320      (clk320),
        .rstn        (rstn),
        .fcIn        (fcIn),
        .aligned     (aligned),
        .frameStrobe (frameStrobe),
        .cmdCode     (cmdCode),
`ifdef FC_ERRCNT_EN
        .errCount    (errCount),
`endif
        .l1a         (l1a),
        .bcr         (bcr),
        .linkReset   (linkReset),
        .chargeInj   (chargeInj),
        .wsStart     (wsStart),
        .wsStop      (wsStop)
    );

    always #2 clk320 = ~clk320;

    // Output activity monitor, sampled away from the active edge.
    always @(negedge clk320) begin
        if (frameStrobe) strobeCnt <= strobeCnt + 1;
        if (aligned) alignedCnt <= alignedCnt + 1;
        if ($countones(pulses) > 1) multiCnt <= multiCnt + 1;
        for (int i = 0; i < 6; i++) begin
            if (pulses[i]) pulseCnt[i] <= pulseCnt[i] + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pulseTotal();
        int t = 0;
        for (int i = 0; i < 6; i++) t += pulseCnt[i];
        return t;
    endfunction

    task automatic sendBit(input logic b);
        @(negedge clk320);
        fcIn = b;
    endtask

    // Sends one frame MSB first. The snapshot taken during it describes the
    // previous frame: its outputs are visible at bit 1 (one edge after the
    // boundary) and must be back to idle-but-held at bit 5.
    task automatic sendFrame(input logic [7:0] code, output snap_t s);
        s = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk320);
            if (i == 1) begin
                s.strobe1  = frameStrobe;
                s.aligned1 = aligned;
                s.code1    = cmdCode;
                s.pulses1  = pulses;
            end
            if (i == 5) begin
                s.strobe5 = frameStrobe;
                s.code5   = cmdCode;
            end
            fcIn = code[7-i];
        end
    endtask

    task automatic checkResetOutputs(input string pfx);
        check({pfx, "_aligned"}, 32'(aligned), 32'd0);
        check({pfx, "_strobe"},  32'(frameStrobe), 32'd0);
        check({pfx, "_cmdCode"}, 32'(cmdCode), 32'hF0);
        check({pfx, "_pulses"},  32'(pulses), 32'd0);
`ifdef FC_ERRCNT_EN
        check({pfx, "_errCount"}, 32'(errCount), 32'd0);
`endif
    endtask

    task automatic doReset();
        @(negedge clk320);
        rstn = 1'b0;
        fcIn = 1'b0;
        repeat (3) @(negedge clk320);
        rstn = 1'b1;
    endtask

    initial begin
        snap_t      s;
        int         base;
        int         base2;
        logic [7:0] cmdTab [6] = '{8'h96, 8'h5A, 8'h33, 8'h69, 8'h3C, 8'hA5};

        // Reset state
        repeat (3) @(negedge clk320);
        checkResetOutputs("rst");
        rstn = 1'b1;

        // Clean IDLE stream at a 3-bit offset: lock on the 4th IDLE
        repeat (3) sendBit(1'b0);
        repeat (3) sendFrame(8'hF0, s);
        sendFrame(8'hF0, s);
        check("lock_f3_aligned", 32'(s.aligned1), 32'd0);
        check("lock_f3_strobe",  32'(s.strobe1), 32'd0);
        sendFrame(8'hF0, s);
        check("lock_f4_aligned", 32'(s.aligned1), 32'd1);
        check("lock_f4_strobe",  32'(s.strobe1), 32'd1);
        check("lock_f4_code",    32'(s.code1), 32'hF0);
        check("lock_f4_pulses",  32'(s.pulses1), 32'd0);
        check("lock_f4_width",   32'(s.strobe5), 32'd0);
        #1 base = strobeCnt;
        repeat (4) sendFrame(8'hF0, s);
        #1 check("idle_strobe_rate", 32'(strobeCnt - base), 32'd4);
        check("idle_no_pulses", 32'(pulseTotal()), 32'd0);

        // One of each command
        for (int i = 0; i < 6; i++) begin
            sendFrame(cmdTab[i], s);
            sendFrame(8'hF0, s);
            check($sformatf("cmd%0d_strobe", i), 32'(s.strobe1), 32'd1);
            check($sformatf("cmd%0d_code", i),   32'(s.code1), 32'(cmdTab[i]));
            check($sformatf("cmd%0d_pulse", i),  32'(s.pulses1), 32'(6'b1 << i));
            check($sformatf("cmd%0d_held", i),   32'(s.code5), 32'(cmdTab[i]));
        end
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("cmd%0d_count", i), 32'(pulseCnt[i]), 32'd1);
        end
        check("cmd_exclusive", 32'(multiCnt), 32'd0);

        // UNLOCK_COUNT-1 invalid frames then IDLE, twice: lock must hold
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                sendFrame(8'h00, s);
                if (k > 0) begin
                    check($sformatf("bad%0d_%0d_aligned", r, k), 32'(s.aligned1), 32'd1);
                    check($sformatf("bad%0d_%0d_strobe", r, k),  32'(s.strobe1), 32'd1);
                    check($sformatf("bad%0d_%0d_code", r, k),    32'(s.code1), 32'h00);
                end
            end
            sendFrame(8'hF0, s);
            check($sformatf("bad%0d_3_pulses", r), 32'(s.pulses1), 32'd0);
            sendFrame(8'hF0, s);
            check($sformatf("bad%0d_keep_aligned", r), 32'(s.aligned1), 32'd1);
            check($sformatf("bad%0d_keep_code", r),    32'(s.code1), 32'hF0);
`ifdef FC_ERRCNT_EN
            check($sformatf("bad%0d_errCount", r), 32'(errCount), 32'(3 * (r + 1)));
`endif
        end

        // UNLOCK_COUNT invalid frames: unlock on the 4th, still strobed
        #1 base = pulseTotal();
        repeat (4) sendFrame(8'h00, s);
        check("unlock_f3_aligned", 32'(s.aligned1), 32'd1);
        sendFrame(8'h00, s);
        check("unlock_f4_aligned", 32'(s.aligned1), 32'd0);
        check("unlock_f4_strobe",  32'(s.strobe1), 32'd1);
        check("unlock_f4_code",    32'(s.code1), 32'h00);
        sendFrame(8'h00, s);
        check("unlock_search_strobe", 32'(s.strobe1), 32'd0);
`ifdef FC_ERRCNT_EN
        check("unlock_errCount", 32'(errCount), 32'd10);
`endif
        // Re-lock at a 1-bit slip
        sendBit(1'b0);
        repeat (4) sendFrame(8'hF0, s);
        check("relock_f3_aligned", 32'(s.aligned1), 32'd0);
        sendFrame(8'hF0, s);
        check("relock_f4_aligned", 32'(s.aligned1), 32'd1);
        check("relock_f4_strobe",  32'(s.strobe1), 32'd1);
        #1 check("unlock_no_pulses", 32'(pulseTotal() - base), 32'd0);

        // CHECK aborted by a non-IDLE frame after 2 IDLEs
        doReset();
        checkResetOutputs("rst2");
        #1 base = alignedCnt;
        base2 = strobeCnt;
        sendFrame(8'hF0, s);
        sendFrame(8'hF0, s);
        sendFrame(8'h96, s);
        repeat (4) sendFrame(8'hF0, s);
        #1 check("abort_aligned_cycles", 32'(alignedCnt - base), 32'd0);
        check("abort_strobes", 32'(strobeCnt - base2), 32'd0);
        check("abort_f6_aligned", 32'(s.aligned1), 32'd0);
        check("abort_no_l1a", 32'(pulseCnt[0]), 32'd1);
        sendFrame(8'hF0, s);
        check("abort_relock_aligned", 32'(s.aligned1), 32'd1);

        // Reset while LOCKED with an L1A frame in flight
        sendFrame(8'h3C, s);
        sendFrame(8'h96, s);
        check("flight_ws_pulse", 32'(s.pulses1), 32'b010000);
        @(negedge clk320);
        check("flight_pre_code", 32'(cmdCode), 32'h3C);
        #1 rstn = 1'b0;
        fcIn = 1'b0;
        #0.5 checkResetOutputs("rst_async");
        repeat (2) @(negedge clk320);
        rstn = 1'b1;
        repeat (16) sendBit(1'b0);
        #1 check("flight_no_l1a", 32'(pulseCnt[0]), 32'd1);
        check("flight_ws_count", 32'(pulseCnt[4]), 32'd2);
        repeat (5) sendFrame(8'hF0, s);
        check("flight_relock_aligned", 32'(s.aligned1), 32'd1);
        check("flight_relock_code", 32'(s.code1), 32'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
